// File: rtl/detector_jogada.sv
// -----------------------------------------------------------------------------
// detector_jogada
//   Input stage for the player switches. The raw inputs are synchronised
//   through two flops and then debounced. A one-hot pattern that stays stable
//   for DEBOUNCE_CYCLES samples is registered as the move. A single-cycle
//   o_jogada_feita pulse is issued for it. A debounced release is then
//   required before the next press is accepted.
//
// Ports
//   i_clock          system clock, rising edge
//   i_reset          synchronous, active-low reset
//   i_chaves[3:0]    raw asynchronous switch/button inputs
//   i_habilita       1 = new presses may be accepted
//   i_zera           synchronous clear of the registered move
//   o_jogada[3:0]    last accepted one-hot pattern
//   o_jogada_feita   1-cycle pulse while the move register has just loaded
//   o_db_estado[2:0] current FSM state code (debug)
// -----------------------------------------------------------------------------
module detector_jogada #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [3:0] i_chaves,
  input  logic       i_habilita,
  input  logic       i_zera,
  output logic [3:0] o_jogada,
  output logic       o_jogada_feita,
  output logic [2:0] o_db_estado
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ESPERA   = 3'b000,
    CONTA    = 3'b001,
    REGISTRA = 3'b010,
    SOLTA    = 3'b011
  } estado_t;

  estado_t         r_estado;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_cand;
  logic [3:0]      r_jogada;
  logic            r_jogada_feita;
  logic [3:0]      r_sync1;
  logic [3:0]      r_sync2;
  logic [3:0]      w_s;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic one_hot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  assign w_s = r_sync2;

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= i_chaves;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce FSM, move register and registered pulse output.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_estado       <= ESPERA;
      r_cnt          <= CNT_ZERO;
      r_cand         <= 4'b0000;
      r_jogada       <= 4'b0000;
      r_jogada_feita <= 1'b0;
    end else begin
      r_jogada_feita <= 1'b0;
      // Clear first so that a load on the same edge overrides it.
      if (i_zera) begin
        r_jogada <= 4'b0000;
      end else begin
        r_jogada <= r_jogada;
      end
      case (r_estado)
        ESPERA: begin
          if (i_habilita && one_hot(w_s)) begin
            r_cand   <= w_s;
            r_cnt    <= CNT_ONE;
            r_estado <= CONTA;
          end else begin
            r_estado <= ESPERA;
          end
        end
        CONTA: begin
          if (!i_habilita || (w_s != r_cand)) begin
            r_cnt    <= CNT_ZERO;
            r_estado <= ESPERA;
          end else if (r_cnt == CNT_LAST) begin
            r_jogada       <= r_cand;
            r_jogada_feita <= 1'b1;
            r_estado       <= REGISTRA;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        REGISTRA: begin
          r_cnt    <= CNT_ZERO;
          r_estado <= SOLTA;
        end
        SOLTA: begin
          // Any key still seen restarts the release count.
          if (w_s != 4'b0000) begin
            r_cnt <= CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            r_cnt    <= CNT_ZERO;
            r_estado <= ESPERA;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_cnt    <= CNT_ZERO;
          r_estado <= ESPERA;
        end
      endcase
    end
  end

  assign o_jogada       = r_jogada;
  assign o_jogada_feita = r_jogada_feita;
  assign o_db_estado    = r_estado;

endmodule
